ctlb_refill_ctrl: RTL and testbench
===================================

// Module: ctlb_refill_ctrl
// PURPOSE
//  Miss/refill sequencer for the code TLB (ctlb). Takes fetch-side ctlb misses and shootdown invalidates,
//  arbitrates them onto the single ctlb write/lookup port, and issues page-walk requests.
//  Walk results are written into the ctlb, and faults are reported back to fetch.
//  Sits between the fetch unit, the ctlb and the page walker; owns the ctlb fStall while active.
// PARAMETERS
//  IP_WIDTH     65                  virtual address width incl. sign/space bit
//  DATA_WIDTH   `ctlbData_width     ctlb payload width (write_data of ctlb)
//  TIMEOUT      255                 walk wait cycles before a retry
//  MAX_RETRY    3                   walk retries before a fault is reported
// PORTS
//  clk            in   1           clock
//  rst            in   1           reset; asynchronous, active-high
//  tlb_init       in   1           ctlb init_pending (init sweep in progress)
//  miss_req       in   1           fetch ctlb miss; held until miss_ack
//  miss_addr      in   IP_WIDTH    missing address
//  miss_nat       in   1           miss is a nat_jump (translated-jump) lookup
//  miss_ack       out  1           1-cycle: entry written or fault reported
//  inv_req        in   1           invalidate request; held until inv_ack
//  inv_addr       in   IP_WIDTH    address to invalidate
//  inv_nat        in   1           invalidate targets validN entries
//  inv_ack        out  1           1-cycle: invalidate applied
//  walk_req       out  1           page-walk request valid
//  walk_addr      out  IP_WIDTH    walk address (registered miss_addr)
//  walk_nat       out  1           walk is for a nat entry
//  walk_gnt       in   1           walker accepted walk_req this cycle
//  walk_rsp_en    in   1           walk response valid (1 cycle)
//  walk_rsp_data  in   DATA_WIDTH  translated ctlb payload
//  walk_rsp_fault in   1           walk failed (no mapping/permission)
//  tlb_stall      out  1           drives ctlb fStall; freezes fetch lookups
//  tlb_addr       out  IP_WIDTH    ctlb address while tlb_stall=1
//  tlb_nat        out  1           ctlb nat_jump while tlb_stall=1
//  tlb_wdata      out  DATA_WIDTH  ctlb write_data
//  tlb_wen        out  1           ctlb write_wen (1 cycle)
//  tlb_inv        out  1           ctlb way invalidate (1 cycle)
//  fault_en       out  1           1-cycle fault report to fetch
//  fault_addr     out  IP_WIDTH    faulting address
//  busy           out  1           state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; retry=0; timer=0; stale=0; all outputs 0. Asynchronous reset mid-walk drops the
//    transaction: any walk_rsp_en arriving outside WAIT is ignored.
//  - While tlb_init=1, stay in IDLE and accept nothing.
//  - IDLE: inv_req has priority over miss_req. inv -> INV. Else miss -> REQ, latching addr/nat.
//    Idle state takes 1 cycle.
//  - REQ: walk_req=1 until walk_gnt, then -> WAIT with timer=0.
//  - WAIT: timer counts up each cycle.
//      walk_rsp_en & ~fault & ~stale -> WRITE.
//      walk_rsp_en & fault -> FAULT.
//      walk_rsp_en & stale -> clear stale, retry++, -> REQ (re-walk).
//      timer==TIMEOUT -> retry++, -> REQ.
//      retry==MAX_RETRY at either increment point -> FAULT instead.
//  - WRITE: tlb_stall=1, tlb_addr=latched addr, tlb_nat=latched nat, tlb_wen=1, tlb_wdata=rsp data
//    (registered on walk_rsp_en). Pulse miss_ack, then -> IDLE. Latency is walk_rsp_en -> tlb_wen = 1 cycle.
//  - FAULT: fault_en=1, fault_addr=latched addr, miss_ack=1, then -> IDLE. No ctlb write.
//  - INV: tlb_stall=1, tlb_addr=inv_addr, tlb_nat=inv_nat, tlb_inv=1 for 1 cycle, inv_ack=1, then -> IDLE.
//  - Invalidate during REQ/WAIT: it is not serviced until IDLE.
//      If the page matches the in-flight address (bits [IP_WIDTH-1:14], or [IP_WIDTH-1:4] when nat),
//      set stale so the pending response is discarded.
//      Simultaneous inv_req and walk_rsp_en with a page match: stale wins.
//  - tlb_stall=0 in IDLE/REQ/WAIT/FAULT; tlb_wen and tlb_inv are never both 1.
//  - timer width = clog2(TIMEOUT+1) and saturates; retry width = clog2(MAX_RETRY+1).
// STRUCTURE
//  - Shared package (struct.sv):
//      state enum {IDLE,REQ,WAIT,WRITE,INV,FAULT};
//      `ctlb_page_lo (14) and `ctlb_nat_page_lo (4) constants.
//  - One sub-module, ctlb_page_match: combinational page compare honoring nat.
//  - Everything else lives in the FSM body.
// TESTING
//  - Miss 0x1_0000_4000, gnt immediate, rsp 3 cycles later with data 0xABC ->
//    tlb_wen=1 with tlb_addr=0x1_0000_4000 1 cycle after rsp; miss_ack same cycle.
//  - inv_req and miss_req asserted in the same IDLE cycle -> tlb_inv/inv_ack first;
//    walk_req appears 2 cycles later.
//  - Inv of same page during WAIT, then rsp -> no tlb_wen; second walk_req issued;
//    second rsp -> tlb_wen.
//  - No rsp, TIMEOUT=255, MAX_RETRY=3 -> 3 walk_req issues, then fault_en and miss_ack,
//    fault_addr=miss_addr.
//  - rsp with walk_rsp_fault=1 -> fault_en 1 cycle later, no tlb_wen.
//  - rst asserted mid-WAIT, then stray walk_rsp_en -> outputs 0 immediately, busy=0,
//    no tlb_wen; tlb_init=1 holds off a pending miss.

Source files
------------

// File: rtl/ctlb_refill_ctrl_pkg.sv
// Shared types and constants for the code-TLB miss/refill sequencer.
package ctlb_refill_ctrl_pkg;

    localparam int unsigned CTLB_IP_WIDTH    = 65;
    localparam int unsigned CTLB_DATA_WIDTH  = 64;
    localparam int unsigned CTLB_PAGE_LO     = 14;
    localparam int unsigned CTLB_NAT_PAGE_LO = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        INV   = 3'd4,
        FAULT = 3'd5
    } state_e;

    // States in which the sequencer owns the ctlb port and freezes fetch lookups.
    function automatic logic is_stall_state(input state_e s);
        return (s == WRITE) || (s == INV);
    endfunction

endpackage

// File: rtl/ctlb_page_match.sv
// Page-granular address compare; nat entries use a finer page boundary.
module ctlb_page_match
    import ctlb_refill_ctrl_pkg::*;
#(
    parameter int unsigned IP_WIDTH = CTLB_IP_WIDTH
) (
    input  logic [IP_WIDTH-1:0] a_addr,
    input  logic [IP_WIDTH-1:0] b_addr,
    input  logic                nat,
    output logic                match_c
);

    localparam logic [IP_WIDTH-1:0] STD_MASK =
        ~((IP_WIDTH'(1) << CTLB_PAGE_LO) - IP_WIDTH'(1));
    localparam logic [IP_WIDTH-1:0] NAT_MASK =
        ~((IP_WIDTH'(1) << CTLB_NAT_PAGE_LO) - IP_WIDTH'(1));

    // Addresses match when every bit above the page offset agrees.
    always_comb begin
        match_c = ((a_addr ^ b_addr) & (nat ? NAT_MASK : STD_MASK)) == '0;
    end

endmodule

// File: rtl/ctlb_refill_ctrl.sv
// Code-TLB miss/refill sequencer: arbitrates misses and invalidates onto the
// ctlb port, drives page walks with timeout/retry, writes results or faults.
module ctlb_refill_ctrl
    import ctlb_refill_ctrl_pkg::*;
#(
    parameter int unsigned IP_WIDTH   = CTLB_IP_WIDTH,
    parameter int unsigned DATA_WIDTH = CTLB_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tlb_init,
    input  logic                  miss_req,
    input  logic [IP_WIDTH-1:0]   miss_addr,
    input  logic                  miss_nat,
    output logic                  miss_ack,
    input  logic                  inv_req,
    input  logic [IP_WIDTH-1:0]   inv_addr,
    input  logic                  inv_nat,
    output logic                  inv_ack,
    output logic                  walk_req,
    output logic [IP_WIDTH-1:0]   walk_addr,
    output logic                  walk_nat,
    input  logic                  walk_gnt,
    input  logic                  walk_rsp_en,
    input  logic [DATA_WIDTH-1:0] walk_rsp_data,
    input  logic                  walk_rsp_fault,
    output logic                  tlb_stall,
    output logic [IP_WIDTH-1:0]   tlb_addr,
    output logic                  tlb_nat,
    output logic [DATA_WIDTH-1:0] tlb_wdata,
    output logic                  tlb_wen,
    output logic                  tlb_inv,
    output logic                  fault_en,
    output logic [IP_WIDTH-1:0]   fault_addr,
    output logic                  busy
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_e                state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [RETRY_W-1:0]    retry_inc;
    logic                  stale_q, stale_d;
    logic                  inv_seen_q, inv_seen_d;
    logic [IP_WIDTH-1:0]   addr_q, addr_d;
    logic                  nat_q, nat_d;

    logic                  miss_ack_q, miss_ack_d;
    logic                  inv_ack_q, inv_ack_d;
    logic                  walk_req_q, walk_req_d;
    logic                  tlb_stall_q, tlb_stall_d;
    logic [IP_WIDTH-1:0]   tlb_addr_q, tlb_addr_d;
    logic                  tlb_nat_q, tlb_nat_d;
    logic [DATA_WIDTH-1:0] tlb_wdata_q, tlb_wdata_d;
    logic                  tlb_wen_q, tlb_wen_d;
    logic                  tlb_inv_q, tlb_inv_d;
    logic                  fault_en_q, fault_en_d;
    logic [IP_WIDTH-1:0]   fault_addr_q, fault_addr_d;
    logic                  busy_q, busy_d;

    logic                  page_match_c;
    logic                  inv_hit;
    logic                  stale_now;
    logic                  rewalk;

    ctlb_page_match #(
        .IP_WIDTH (IP_WIDTH)
    ) u_page_match (
        .a_addr  (addr_q),
        .b_addr  (inv_addr),
        .nat     (inv_nat),
        .match_c (page_match_c)
    );

    // Next-state, bookkeeping and registered-output values.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        stale_d    = stale_q;
        inv_seen_d = inv_seen_q;
        addr_d     = addr_q;
        nat_d      = nat_q;
        rewalk     = 1'b0;
        retry_inc  = retry_q + 1'b1;
        // An invalidate only poisons the walk once, on the first cycle it is seen.
        inv_hit    = inv_req && !inv_seen_q && page_match_c;
        stale_now  = stale_q || inv_hit;

        unique case (state_q)
            IDLE: begin
                if (!tlb_init) begin
                    if (inv_req) begin
                        state_d = INV;
                    end else if (miss_req) begin
                        state_d    = REQ;
                        addr_d     = miss_addr;
                        nat_d      = miss_nat;
                        retry_d    = '0;
                        stale_d    = 1'b0;
                        inv_seen_d = 1'b0;
                    end
                end
            end
            REQ: begin
                if (inv_req) inv_seen_d = 1'b1;
                if (inv_hit) stale_d = 1'b1;
                if (walk_gnt) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                if (inv_req) inv_seen_d = 1'b1;
                if (inv_hit) stale_d = 1'b1;
                if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
                if (walk_rsp_en) begin
                    if (stale_now) begin
                        stale_d = 1'b0;
                        rewalk  = 1'b1;
                    end else if (walk_rsp_fault) begin
                        state_d = FAULT;
                    end else begin
                        state_d = WRITE;
                    end
                end else if (timer_q == TIMER_MAX) begin
                    // The abandoned walk's response can no longer be accepted.
                    stale_d = 1'b0;
                    rewalk  = 1'b1;
                end
            end
            INV: begin
                inv_seen_d = 1'b0;
                state_d    = IDLE;
            end
            WRITE, FAULT: state_d = IDLE;
            default:      state_d = IDLE;
        endcase

        if (rewalk) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_MAX) ? FAULT : REQ;
        end

        walk_req_d   = (state_d == REQ);
        busy_d       = (state_d != IDLE);
        tlb_stall_d  = is_stall_state(state_d);
        tlb_wen_d    = (state_d == WRITE);
        tlb_inv_d    = (state_d == INV);
        inv_ack_d    = (state_d == INV);
        miss_ack_d   = (state_d == WRITE) || (state_d == FAULT);
        fault_en_d   = (state_d == FAULT);
        fault_addr_d = (state_d == FAULT) ? addr_d : '0;
        tlb_wdata_d  = (state_d == WRITE) ? walk_rsp_data : '0;
        tlb_addr_d   = '0;
        tlb_nat_d    = 1'b0;
        if (state_d == WRITE) begin
            tlb_addr_d = addr_d;
            tlb_nat_d  = nat_d;
        end else if (state_d == INV) begin
            tlb_addr_d = inv_addr;
            tlb_nat_d  = inv_nat;
        end
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            retry_q      <= '0;
            stale_q      <= 1'b0;
            inv_seen_q   <= 1'b0;
            addr_q       <= '0;
            nat_q        <= 1'b0;
            miss_ack_q   <= 1'b0;
            inv_ack_q    <= 1'b0;
            walk_req_q   <= 1'b0;
            tlb_stall_q  <= 1'b0;
            tlb_addr_q   <= '0;
            tlb_nat_q    <= 1'b0;
            tlb_wdata_q  <= '0;
            tlb_wen_q    <= 1'b0;
            tlb_inv_q    <= 1'b0;
            fault_en_q   <= 1'b0;
            fault_addr_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            stale_q      <= stale_d;
            inv_seen_q   <= inv_seen_d;
            addr_q       <= addr_d;
            nat_q        <= nat_d;
            miss_ack_q   <= miss_ack_d;
            inv_ack_q    <= inv_ack_d;
            walk_req_q   <= walk_req_d;
            tlb_stall_q  <= tlb_stall_d;
            tlb_addr_q   <= tlb_addr_d;
            tlb_nat_q    <= tlb_nat_d;
            tlb_wdata_q  <= tlb_wdata_d;
            tlb_wen_q    <= tlb_wen_d;
            tlb_inv_q    <= tlb_inv_d;
            fault_en_q   <= fault_en_d;
            fault_addr_q <= fault_addr_d;
            busy_q       <= busy_d;
        end
    end

    assign miss_ack   = miss_ack_q;
    assign inv_ack    = inv_ack_q;
    assign walk_req   = walk_req_q;
    assign walk_addr  = addr_q;
    assign walk_nat   = nat_q;
    assign tlb_stall  = tlb_stall_q;
    assign tlb_addr   = tlb_addr_q;
    assign tlb_nat    = tlb_nat_q;
    assign tlb_wdata  = tlb_wdata_q;
    assign tlb_wen    = tlb_wen_q;
    assign tlb_inv    = tlb_inv_q;
    assign fault_en   = fault_en_q;
    assign fault_addr = fault_addr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ctlb_refill_ctrl.sv
// Bench for ctlb_refill_ctrl: directed scenarios plus randomized miss/invalidate races.
module tb_ctlb_refill_ctrl;

    localparam int unsigned AW        = 65;
    localparam int unsigned DW        = 64;
    localparam int unsigned TIMEOUT   = 255;
    localparam int unsigned MAX_RETRY = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          tlb_init;
    logic          miss_req;
    logic [AW-1:0] miss_addr;
    logic          miss_nat;
    logic          miss_ack;
    logic          inv_req;
    logic [AW-1:0] inv_addr;
    logic          inv_nat;
    logic          inv_ack;
    logic          walk_req;
    logic [AW-1:0] walk_addr;
    logic          walk_nat;
    logic          walk_gnt;
    logic          walk_rsp_en;
    logic [DW-1:0] walk_rsp_data;
    logic          walk_rsp_fault;
    logic          tlb_stall;
    logic [AW-1:0] tlb_addr;
    logic          tlb_nat;
    logic [DW-1:0] tlb_wdata;
    logic          tlb_wen;
    logic          tlb_inv;
    logic          fault_en;
    logic [AW-1:0] fault_addr;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    ctlb_refill_ctrl #(
        .IP_WIDTH   (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TIMEOUT),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tlb_init       (tlb_init),
        .miss_req       (miss_req),
        .miss_addr      (miss_addr),
        .miss_nat       (miss_nat),
        .miss_ack       (miss_ack),
        .inv_req        (inv_req),
        .inv_addr       (inv_addr),
        .inv_nat        (inv_nat),
        .inv_ack        (inv_ack),
        .walk_req       (walk_req),
        .walk_addr      (walk_addr),
        .walk_nat       (walk_nat),
        .walk_gnt       (walk_gnt),
        .walk_rsp_en    (walk_rsp_en),
        .walk_rsp_data  (walk_rsp_data),
        .walk_rsp_fault (walk_rsp_fault),
        .tlb_stall      (tlb_stall),
        .tlb_addr       (tlb_addr),
        .tlb_nat        (tlb_nat),
        .tlb_wdata      (tlb_wdata),
        .tlb_wen        (tlb_wen),
        .tlb_inv        (tlb_inv),
        .fault_en       (fault_en),
        .fault_addr     (fault_addr),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference rule: same page above the offset, offset size chosen by the invalidate's nat.
    function automatic bit model_page_match(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic nat);
        int lo;
        lo = nat ? 4 : 14;
        return (a >> lo) == (b >> lo);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return {1'($urandom), $urandom, $urandom};
    endfunction

    task automatic wait_walk_req(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (walk_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic grant_walk();
        walk_gnt = 1'b1;
        @(negedge clk);
        walk_gnt = 1'b0;
    endtask

    task automatic pulse_rsp(input logic [DW-1:0] d, input logic f);
        walk_rsp_en    = 1'b1;
        walk_rsp_data  = d;
        walk_rsp_fault = f;
        @(negedge clk);
        walk_rsp_en    = 1'b0;
        walk_rsp_fault = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tlb_init = 1'b0; miss_req = 1'b0; miss_addr = '0; miss_nat = 1'b0;
        inv_req = 1'b0; inv_addr = '0; inv_nat = 1'b0; walk_gnt = 1'b0;
        walk_rsp_en = 1'b0; walk_rsp_data = '0; walk_rsp_fault = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, walk_req, tlb_stall, tlb_wen, tlb_inv, miss_ack, inv_ack, fault_en, walk_nat, tlb_nat} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0", {busy, walk_req, tlb_stall, tlb_wen, tlb_inv, miss_ack, inv_ack, fault_en, walk_nat, tlb_nat});
        end
        n_checks++;
        if ((tlb_addr | walk_addr | fault_addr) !== '0 || tlb_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: tlb_addr=%h walk_addr=%h fault_addr=%h wdata=%h want 0", tlb_addr, walk_addr, fault_addr, tlb_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_miss_write();
        logic [AW-1:0] a;
        a = 65'h1_0000_4000;
        miss_req = 1'b1; miss_addr = a; miss_nat = 1'b0;
        @(negedge clk);
        n_checks++;
        if (walk_req !== 1'b1 || walk_addr !== a) begin
            n_fail++; $display("FAIL miss_walk_req: walk_req=%b addr=%h want 1 %h", walk_req, walk_addr, a);
        end
        grant_walk();
        n_checks++;
        if (walk_req !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL miss_after_gnt: walk_req=%b busy=%b want 0 1", walk_req, busy);
        end
        repeat (2) @(negedge clk);
        pulse_rsp(64'hABC, 1'b0);
        n_checks++;
        if (tlb_wen !== 1'b1 || miss_ack !== 1'b1 || tlb_stall !== 1'b1 || tlb_inv !== 1'b0) begin
            n_fail++; $display("FAIL miss_write_ctrl: wen=%b ack=%b stall=%b inv=%b want 1 1 1 0", tlb_wen, miss_ack, tlb_stall, tlb_inv);
        end
        n_checks++;
        if (tlb_addr !== a || tlb_wdata !== 64'hABC || tlb_nat !== 1'b0) begin
            n_fail++; $display("FAIL miss_write_data: addr=%h data=%h nat=%b want %h abc 0", tlb_addr, tlb_wdata, tlb_nat, a);
        end
        miss_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tlb_wen !== 1'b0 || busy !== 1'b0 || tlb_stall !== 1'b0 || miss_ack !== 1'b0) begin
            n_fail++; $display("FAIL miss_done: wen=%b busy=%b stall=%b ack=%b want 0", tlb_wen, busy, tlb_stall, miss_ack);
        end
    endtask

    task automatic test_inv_priority();
        logic [AW-1:0] ia, ma;
        logic [DW-1:0] d;
        ia = rand_addr(); ma = rand_addr(); d = {$urandom, $urandom};
        inv_req = 1'b1; inv_addr = ia; inv_nat = 1'b1;
        miss_req = 1'b1; miss_addr = ma; miss_nat = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tlb_inv !== 1'b1 || inv_ack !== 1'b1 || tlb_stall !== 1'b1 || tlb_wen !== 1'b0 || walk_req !== 1'b0) begin
            n_fail++; $display("FAIL inv_first: inv=%b ack=%b stall=%b wen=%b walk_req=%b want 1 1 1 0 0", tlb_inv, inv_ack, tlb_stall, tlb_wen, walk_req);
        end
        n_checks++;
        if (tlb_addr !== ia || tlb_nat !== 1'b1) begin
            n_fail++; $display("FAIL inv_addr: addr=%h nat=%b want %h 1", tlb_addr, tlb_nat, ia);
        end
        inv_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (walk_req !== 1'b0 || tlb_inv !== 1'b0) begin
            n_fail++; $display("FAIL inv_idle_gap: walk_req=%b inv=%b want 0 0", walk_req, tlb_inv);
        end
        @(negedge clk);
        n_checks++;
        if (walk_req !== 1'b1 || walk_addr !== ma || walk_nat !== 1'b1) begin
            n_fail++; $display("FAIL inv_then_walk: walk_req=%b addr=%h nat=%b want 1 %h 1", walk_req, walk_addr, walk_nat, ma);
        end
        grant_walk();
        pulse_rsp(d, 1'b0);
        n_checks++;
        if (tlb_wen !== 1'b1 || tlb_wdata !== d || tlb_addr !== ma || tlb_nat !== 1'b1) begin
            n_fail++; $display("FAIL inv_then_write: wen=%b data=%h addr=%h want 1 %h %h", tlb_wen, tlb_wdata, tlb_addr, d, ma);
        end
        miss_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_inv_race(input int n);
        for (int it = 0; it < n; it++) begin
            logic [AW-1:0] m, ia;
            logic [DW-1:0] d1, d2, want_d;
            logic          mnat, inat, sim, want_match;
            bit            stale_exp, ok;
            int            lo;
            m = rand_addr(); d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
            mnat = 1'($urandom); inat = 1'($urandom); sim = 1'($urandom); want_match = 1'($urandom);
            lo = inat ? 4 : 14;
            if (want_match)
                ia = ((m >> lo) << lo) | ({1'b0, $urandom, $urandom} & ((65'd1 << lo) - 65'd1));
            else
                ia = m ^ (65'd1 << (lo + int'($urandom_range(0, 40))));
            stale_exp = model_page_match(m, ia, inat);
            want_d = stale_exp ? d2 : d1;

            miss_req = 1'b1; miss_addr = m; miss_nat = mnat;
            @(negedge clk);
            wait_walk_req(10, ok);
            n_checks++;
            if (!ok || walk_addr !== m || walk_nat !== mnat) begin
                n_fail++; $display("FAIL race_walk1 it%0d: seen=%b addr=%h want 1 %h", it, ok, walk_addr, m);
            end
            grant_walk();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            inv_req = 1'b1; inv_addr = ia; inv_nat = inat;
            if (!sim) @(negedge clk);
            pulse_rsp(d1, 1'b0);
            if (stale_exp) begin
                n_checks++;
                if (tlb_wen !== 1'b0 || walk_req !== 1'b1) begin
                    n_fail++; $display("FAIL race_discard it%0d: wen=%b walk_req=%b want 0 1", it, tlb_wen, walk_req);
                end
                grant_walk();
                repeat ($urandom_range(0, 2)) @(negedge clk);
                pulse_rsp(d2, 1'b0);
            end
            n_checks++;
            if (tlb_wen !== 1'b1 || miss_ack !== 1'b1 || tlb_wdata !== want_d || tlb_addr !== m) begin
                n_fail++; $display("FAIL race_write it%0d: wen=%b ack=%b data=%h addr=%h want 1 1 %h %h", it, tlb_wen, miss_ack, tlb_wdata, tlb_addr, want_d, m);
            end
            miss_req = 1'b0;
            ok = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (inv_ack === 1'b1) begin ok = 1'b1; break; end
            end
            n_checks++;
            if (!ok || tlb_inv !== 1'b1 || tlb_addr !== ia || tlb_nat !== inat || tlb_wen !== 1'b0) begin
                n_fail++; $display("FAIL race_inv it%0d: ack=%b inv=%b addr=%h nat=%b want 1 1 %h %b", it, ok, tlb_inv, tlb_addr, tlb_nat, ia, inat);
            end
            inv_req = 1'b0;
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL race_idle it%0d: busy=%b want 0", it, busy); end
        end
    endtask

    task automatic test_timeout();
        logic [AW-1:0] a;
        int n_issue, wen_seen, first_issue, second_issue;
        bit got_fault;
        a = rand_addr();
        n_issue = 0; wen_seen = 0; got_fault = 1'b0; first_issue = -1; second_issue = -1;
        miss_req = 1'b1; miss_addr = a; miss_nat = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            walk_gnt = 1'b0;
            if (tlb_wen === 1'b1) wen_seen++;
            if (fault_en === 1'b1) begin got_fault = 1'b1; break; end
            if (walk_req === 1'b1) begin
                walk_gnt = 1'b1;
                if (n_issue == 0) first_issue = c;
                if (n_issue == 1) second_issue = c;
                n_issue++;
            end
        end
        n_checks++;
        if (!got_fault || n_issue != MAX_RETRY || wen_seen != 0) begin
            n_fail++; $display("FAIL timeout_count: fault=%b issues=%0d wens=%0d want 1 %0d 0", got_fault, n_issue, wen_seen, MAX_RETRY);
        end
        n_checks++;
        if (second_issue - first_issue != int'(TIMEOUT) + 2) begin
            n_fail++; $display("FAIL timeout_gap: gap=%0d want %0d", second_issue - first_issue, TIMEOUT + 2);
        end
        n_checks++;
        if (fault_addr !== a || miss_ack !== 1'b1 || tlb_stall !== 1'b0 || tlb_wen !== 1'b0) begin
            n_fail++; $display("FAIL timeout_fault: addr=%h ack=%b stall=%b wen=%b want %h 1 0 0", fault_addr, miss_ack, tlb_stall, tlb_wen, a);
        end
        miss_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fault_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_done: fault_en=%b busy=%b want 0 0", fault_en, busy);
        end
    endtask

    task automatic test_rsp_fault();
        logic [AW-1:0] a;
        bit ok;
        a = rand_addr();
        miss_req = 1'b1; miss_addr = a; miss_nat = 1'b1;
        @(negedge clk);
        wait_walk_req(10, ok);
        grant_walk();
        @(negedge clk);
        pulse_rsp({$urandom, $urandom}, 1'b1);
        n_checks++;
        if (!ok || fault_en !== 1'b1 || miss_ack !== 1'b1 || tlb_wen !== 1'b0 || fault_addr !== a) begin
            n_fail++; $display("FAIL rsp_fault: walk=%b fault=%b ack=%b wen=%b addr=%h want 1 1 1 0 %h", ok, fault_en, miss_ack, tlb_wen, fault_addr, a);
        end
        miss_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fault_en !== 1'b0 || busy !== 1'b0 || tlb_wen !== 1'b0) begin
            n_fail++; $display("FAIL rsp_fault_done: fault=%b busy=%b wen=%b want 0", fault_en, busy, tlb_wen);
        end
    endtask

    task automatic test_rst_midwalk();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit ok, held;
        a = rand_addr(); d = {$urandom, $urandom};
        miss_req = 1'b1; miss_addr = a; miss_nat = 1'b0;
        @(negedge clk);
        wait_walk_req(10, ok);
        grant_walk();
        repeat (2) @(negedge clk);
        rst = 1'b1; tlb_init = 1'b1;
        #1;
        n_checks++;
        if ({busy, walk_req, tlb_wen, miss_ack, fault_en, tlb_stall} !== 6'b0 || walk_addr !== '0) begin
            n_fail++; $display("FAIL rst_async: ctrl=%b walk_addr=%h want 0", {busy, walk_req, tlb_wen, miss_ack, fault_en, tlb_stall}, walk_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_rsp(d, 1'b0);
        n_checks++;
        if (tlb_wen !== 1'b0 || busy !== 1'b0 || miss_ack !== 1'b0) begin
            n_fail++; $display("FAIL rst_stray_rsp: wen=%b busy=%b ack=%b want 0", tlb_wen, busy, miss_ack);
        end
        held = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0 || walk_req !== 1'b0) held = 1'b0;
        end
        n_checks++;
        if (!held) begin n_fail++; $display("FAIL init_holdoff: busy=%b walk_req=%b want 0 0", busy, walk_req); end
        tlb_init = 1'b0;
        @(negedge clk);
        n_checks++;
        if (walk_req !== 1'b1 || walk_addr !== a) begin
            n_fail++; $display("FAIL init_release: walk_req=%b addr=%h want 1 %h", walk_req, walk_addr, a);
        end
        grant_walk();
        pulse_rsp(d, 1'b0);
        n_checks++;
        if (tlb_wen !== 1'b1 || tlb_wdata !== d || tlb_addr !== a) begin
            n_fail++; $display("FAIL init_write: wen=%b data=%h addr=%h want 1 %h %h", tlb_wen, tlb_wdata, tlb_addr, d, a);
        end
        miss_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_miss_write();
        test_inv_priority();
        test_inv_race(12);
        test_rsp_fault();
        test_timeout();
        test_rst_midwalk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
